// File: rtl/dpwm_multicanal.sv
// dpwm_multicanal: CHANNELS-wide DPWM on a shared prescaled period counter.
// Up/down buttons step duty[sel] (fine or coarse) with hold auto-repeat;
// btn_sel cycles the selected channel. A 4-digit muxed 7-seg shows sel and
// duty[sel] in hex. Optional macro PHASE_STAGGER_EN offsets each channel's
// compare phase by k*2^WIDTH/CHANNELS ticks to spread switching edges.
module dpwm_multicanal #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int PRESCALE    = 1,
  parameter int STEP        = 16,
  parameter int REPEAT_DLY  = 50000000,
  parameter int REPEAT_RATE = 10000000,
  parameter int REFRESH     = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          botones,
  input  logic                btn_sel,
  input  logic                funcion,
  output logic [CHANNELS-1:0] senal,
  output logic [7:0]          catodos,
  output logic [3:0]          anodos
);
  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RMX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RCW = $clog2(RMX + 1);
  localparam int FW  = $clog2(REFRESH + 1);
  localparam logic [WIDTH-1:0] HALF = WIDTH'(1 << (WIDTH - 1));
  localparam logic [WIDTH-1:0] MAXV = '1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  logic [1:0] b_s1_q, b_s2_q, b_prev_q;
  logic       s_s1_q, s_s2_q, s_prev_q;
  logic [CHANNELS-1:0][WIDTH-1:0] duty_q;
  logic [SW-1:0]  sel_q;
  state_t         st_q;
  logic           dir_up_q;
  logic [RCW-1:0] rc_q, rc_last;
  logic [PW-1:0]  pre_q;
  logic [WIDTH-1:0] cnt_q;
  logic [FW-1:0]  ref_q;
  logic [1:0]     dig_q;
  logic [3:0]     an_q;
  logic [7:0]     cat_q;

  logic sel_rise, only_up, only_dn, new_up, new_dn, held, tick, wrap;
  logic [WIDTH:0]   cur, stepv, up_sum;
  logic [WIDTH-1:0] up_val, dn_val;
  logic [11:0]      disp;
  logic [3:0]       nib;

  // Two-flop synchronisers plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      b_s1_q <= '0; b_s2_q <= '0; b_prev_q <= '0;
      s_s1_q <= 1'b0; s_s2_q <= 1'b0; s_prev_q <= 1'b0;
    end else begin
      b_s1_q <= botones; b_s2_q <= b_s1_q; b_prev_q <= b_s2_q;
      s_s1_q <= btn_sel; s_s2_q <= s_s1_q; s_prev_q <= s_s2_q;
    end
  end

  assign sel_rise = s_s2_q & ~s_prev_q;
  assign only_up  = (b_s2_q == 2'b10);
  assign only_dn  = (b_s2_q == 2'b01);
  assign new_up   = b_s2_q[1] & ~b_prev_q[1];
  assign new_dn   = b_s2_q[0] & ~b_prev_q[0];
  assign held     = dir_up_q ? only_up : only_dn;
  assign rc_last  = (st_q == S_HOLD) ? RCW'(REPEAT_DLY - 1) : RCW'(REPEAT_RATE - 1);

  // Saturating step candidates for the selected channel, one bit of headroom
  always_comb begin
    cur    = {1'b0, duty_q[sel_q]};
    stepv  = funcion ? (WIDTH+1)'(STEP) : (WIDTH+1)'(1);
    up_sum = cur + stepv;
    up_val = (up_sum > {1'b0, MAXV}) ? MAXV : up_sum[WIDTH-1:0];
    dn_val = (cur < stepv) ? '0 : WIDTH'(cur - stepv);
  end

  // Channel select and duty FSM; a select press cancels any hold/repeat
  always_ff @(posedge clk) begin
    if (!rst) begin
      duty_q   <= {CHANNELS{HALF}};
      sel_q    <= '0;
      st_q     <= S_IDLE;
      rc_q     <= '0;
      dir_up_q <= 1'b0;
    end else if (sel_rise) begin
      sel_q <= (sel_q == SW'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;
      st_q  <= S_IDLE;
      rc_q  <= '0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          rc_q <= '0;
          if (only_up && new_up) begin
            duty_q[sel_q] <= up_val; dir_up_q <= 1'b1; st_q <= S_HOLD;
          end else if (only_dn && new_dn) begin
            duty_q[sel_q] <= dn_val; dir_up_q <= 1'b0; st_q <= S_HOLD;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (!held) begin
            st_q <= S_IDLE; rc_q <= '0;
          end else if (rc_q == rc_last) begin
            duty_q[sel_q] <= dir_up_q ? up_val : dn_val;
            st_q <= S_REPEAT; rc_q <= '0;
          end else begin
            rc_q <= rc_q + 1'b1;
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign tick = (pre_q == PW'(PRESCALE - 1));
  assign wrap = tick && (cnt_q == MAXV);

  // Shared prescaler and period counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q <= '0; cnt_q <= '0;
    end else if (tick) begin
      pre_q <= '0; cnt_q <= cnt_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
`ifdef PHASE_STAGGER_EN
    localparam logic [WIDTH-1:0] OFF = WIDTH'(k * ((1 << WIDTH) / CHANNELS));
`else
    localparam logic [WIDTH-1:0] OFF = '0;
`endif
    logic [WIDTH-1:0] phase, shadow_q;
    logic             sen_q;
    assign phase    = cnt_q + OFF;
    assign senal[k] = sen_q;
    // Shadow duty latched only at period wrap, then compared every clk
    always_ff @(posedge clk) begin
      if (!rst) begin
        shadow_q <= HALF; sen_q <= 1'b0;
      end else begin
        if (wrap) shadow_q <= duty_q[k];
        sen_q <= (phase < shadow_q);
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    unique case (v)
      4'h0: seg7 = 7'h3F; 4'h1: seg7 = 7'h06; 4'h2: seg7 = 7'h5B; 4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66; 4'h5: seg7 = 7'h6D; 4'h6: seg7 = 7'h7D; 4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F; 4'h9: seg7 = 7'h6F; 4'hA: seg7 = 7'h77; 4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39; 4'hD: seg7 = 7'h5E; 4'hE: seg7 = 7'h79; default: seg7 = 7'h71;
    endcase
  endfunction

  // Nibble for the digit currently being driven
  always_comb begin
    disp = 12'(duty_q[sel_q]);
    unique case (dig_q)
      2'd0:    nib = disp[3:0];
      2'd1:    nib = disp[7:4];
      2'd2:    nib = disp[11:8];
      default: nib = 4'(sel_q);
    endcase
  end

  // Digit scan; anode and cathode registers update together
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_q <= '0; dig_q <= '0; an_q <= 4'hF; cat_q <= 8'hFF;
    end else begin
      if (ref_q == FW'(REFRESH - 1)) begin
        ref_q <= '0; dig_q <= dig_q + 2'd1;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
      an_q  <= ~(4'b0001 << dig_q);
      cat_q <= {1'b1, ~seg7(nib)};
    end
  end

  assign anodos  = an_q;
  assign catodos = cat_q;
endmodule

// File: tb/tb_dpwm_multicanal.sv
// Bench for dpwm_multicanal: directed scenarios plus random button traffic,
// all checked each cycle against a behavioural model of the spec rules.
module tb_dpwm_multicanal;
  localparam int CH = 4, W = 8, PRE = 1, STEP = 16, DLY = 20, RATE = 5, REF = 4;
  localparam int PER = 1 << W;

  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] botones = 2'b00;
  logic btn_sel = 1'b0, funcion = 1'b0;
  logic [CH-1:0] senal;
  logic [7:0] catodos;
  logic [3:0] anodos;

  dpwm_multicanal #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PRE), .STEP(STEP),
    .REPEAT_DLY(DLY), .REPEAT_RATE(RATE), .REFRESH(REF)) dut (
    .clk(clk), .rst(rst), .botones(botones), .btn_sel(btn_sel), .funcion(funcion),
    .senal(senal), .catodos(catodos), .anodos(anodos));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  n, m_sel, m_start, m_cnt, m_dig, m_val, m_age;
  int  m_duty[CH], m_shadow[CH];
  bit  m_active, m_dir_up, chk_en = 0;
  logic [2:0] hist[3];             // {btn_sel,botones} seen at last 3 edges, [0] newest
  logic [1:0] seen, prev;
  logic [CH-1:0] exp_senal;
  logic [7:0] exp_cat;
  logic [3:0] exp_an;

  function automatic logic [7:0] seg_code(input int v);
    logic [7:0] tbl[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[v & 15];
  endfunction

  function automatic int phase_off(input int k);
`ifdef PHASE_STAGGER_EN
    return k * (PER / CH);
`else
    return 0 * k;
`endif
  endfunction

  function automatic int stepped(input int d, input bit up, input bit coarse);
    int s, r;
    s = coarse ? STEP : 1;
    r = up ? d + s : d - s;
    if (r < 0) r = 0;
    if (r > PER - 1) r = PER - 1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      n = 0; m_sel = 0; m_active = 0; m_dir_up = 0; m_start = 0;
      for (int k = 0; k < CH; k++) begin m_duty[k] = PER / 2; m_shadow[k] = PER / 2; end
      for (int i = 0; i < 3; i++) hist[i] = '0;
      exp_senal = '0; exp_an = 4'hF; exp_cat = 8'hFF;
    end else begin
      // outputs are a function of state before this edge
      m_cnt = (n / PRE) % PER;
      for (int k = 0; k < CH; k++)
        exp_senal[k] = (((m_cnt + phase_off(k)) % PER) < m_shadow[k]);
      m_dig = (n / REF) % 4;
      exp_an = 4'hF & ~(4'b0001 << m_dig);
      m_val = (m_dig == 3) ? m_sel : ((m_duty[m_sel] >> (4 * m_dig)) & 15);
      exp_cat = seg_code(m_val);
      if ((n % PRE) == PRE - 1 && m_cnt == PER - 1)
        for (int k = 0; k < CH; k++) m_shadow[k] = m_duty[k];
      // buttons as seen two edges after sampling
      seen = hist[1][1:0]; prev = hist[2][1:0];
      if (hist[1][2] && !hist[2][2]) begin
        m_sel = (m_sel + 1) % CH; m_active = 0;
      end else if (m_active) begin
        if (seen != (m_dir_up ? 2'b10 : 2'b01)) m_active = 0;
        else begin
          m_age = n - m_start;
          if (m_age == DLY || (m_age > DLY && ((m_age - DLY) % RATE) == 0))
            m_duty[m_sel] = stepped(m_duty[m_sel], m_dir_up, funcion);
        end
      end else if (seen == 2'b10 && !prev[1]) begin
        m_duty[m_sel] = stepped(m_duty[m_sel], 1'b1, funcion);
        m_active = 1; m_dir_up = 1; m_start = n;
      end else if (seen == 2'b01 && !prev[0]) begin
        m_duty[m_sel] = stepped(m_duty[m_sel], 1'b0, funcion);
        m_active = 1; m_dir_up = 0; m_start = n;
      end
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = {btn_sel, botones};
      n++;
    end
    chk_en = 1;
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("senal", 32'(senal), 32'(exp_senal));
      cmp("anodos", 32'(anodos), 32'(exp_an));
      cmp("catodos", 32'(catodos), 32'(exp_cat));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic hold_btn(input logic [1:0] b, input int c);
    botones = b;
    repeat (c) @(negedge clk);
    botones = 2'b00;
  endtask

  task automatic check_digit(input string name, input logic [3:0] an, input logic [7:0] cat);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (anodos === an) ok = 1;
    end
    if (ok) cmp(name, 32'(catodos), 32'(cat));
    else begin
      total++; bad++;
      $display("FAIL %s: anodos never reached %b (got %b)", name, an, anodos);
    end
  endtask

  task automatic count_high(input int ch, output int hi);
    hi = 0;
    repeat (PER) begin
      @(negedge clk);
      if (senal[ch]) hi++;
    end
  endtask

  int hi[CH];
  int h;

  initial begin
    // 1. reset and default 50% duty
    repeat (3) @(negedge clk);
    cmp("rst_senal", 32'(senal), 32'h0);
    cmp("rst_anodos", 32'(anodos), 32'hF);
    cmp("rst_catodos", 32'(catodos), 32'hFF);
    rst = 1'b1;
    for (int k = 0; k < CH; k++) hi[k] = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) if (senal[k]) hi[k]++;
      if (i == 0)  cmp("an_first", 32'(anodos), 32'b1110);
      if (i == 4)  cmp("an_second", 32'(anodos), 32'b1101);
      if (i == 8)  cmp("an_third", 32'(anodos), 32'b1011);
      if (i == 12) cmp("an_fourth", 32'(anodos), 32'b0111);
      if (i == 16) cmp("an_wrap", 32'(anodos), 32'b1110);
`ifdef PHASE_STAGGER_EN
      if (i == 0)   cmp("stagger_cnt0", 32'(senal), 32'b0011);
      if (i == 192) cmp("stagger_cnt192", 32'(senal), 32'b0110);
`else
      if (i == 0)   cmp("align_cnt0", 32'(senal), 32'b1111);
      if (i == 192) cmp("align_cnt192", 32'(senal), 32'b0000);
`endif
    end
    for (int k = 0; k < CH; k++) cmp("t1_high", 32'(hi[k]), 32'd128);

    // 2. single coarse up -> 0x90
    funcion = 1'b1;
    hold_btn(2'b10, 1);
    idle(6);
    check_digit("t2_d1", 4'b1101, 8'h90);
    check_digit("t2_d0", 4'b1110, 8'hC0);
    check_digit("t2_d2", 4'b1011, 8'hC0);
    check_digit("t2_d3", 4'b0111, 8'hC0);
    idle(300);
    count_high(0, h); cmp("t2_high_ch0", 32'(h), 32'd144);
    count_high(1, h); cmp("t2_high_ch1", 32'(h), 32'd128);

    // 3. fine down held with auto-repeat -> 0x88
    funcion = 1'b0;
    hold_btn(2'b01, 51);
    idle(5);
    check_digit("t3_d1", 4'b1101, 8'h80);
    check_digit("t3_d0", 4'b1110, 8'h80);

    // 4. saturation at both ends
    funcion = 1'b1;
    hold_btn(2'b10, 60);
    idle(5);
    check_digit("t4_hi_d1", 4'b1101, 8'h8E);
    check_digit("t4_hi_d0", 4'b1110, 8'h8E);
    hold_btn(2'b01, 150);
    idle(5);
    check_digit("t4_lo_d1", 4'b1101, 8'hC0);
    check_digit("t4_lo_d0", 4'b1110, 8'hC0);
    idle(300);
    count_high(0, h); cmp("t4_zero_high", 32'(h), 32'd0);

    // 5. channel select wrap, both-buttons, reset mid-repeat
    repeat (5) begin
      btn_sel = 1'b1; idle(2); btn_sel = 1'b0; idle(3);
    end
    idle(4);
    check_digit("t5_sel", 4'b0111, 8'hF9);
    check_digit("t5_ch1_d1", 4'b1101, 8'h80);
    hold_btn(2'b11, 10);
    idle(4);
    check_digit("t5_both_d1", 4'b1101, 8'h80);
    check_digit("t5_both_d0", 4'b1110, 8'hC0);
    funcion = 1'b0;
    botones = 2'b10;
    idle(35);
    rst = 1'b0; botones = 2'b00;
    idle(3);
    rst = 1'b1;
    idle(6);
    check_digit("t5_rst_sel", 4'b0111, 8'hC0);
    check_digit("t5_rst_d1", 4'b1101, 8'h80);
    check_digit("t5_rst_d0", 4'b1110, 8'hC0);

    // random traffic, model-checked every cycle
    repeat (120) begin
      int r;
      r = $urandom_range(0, 99);
      funcion = 1'($urandom_range(0, 1));
      botones = 2'($urandom_range(0, 3));
      btn_sel = (r < 8);
      if (r == 99) rst = 1'b0;
      idle($urandom_range(1, 45));
      botones = 2'b00; btn_sel = 1'b0; rst = 1'b1;
      idle($urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
